apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- Downstream consumer of the AHB-to-APB bridge. Models the four APB peripherals addressed by the one-hot `Pselx[3:0]`.
- Each select bit owns a small register bank. The block accepts bridge setup/access cycles and commits writes. It returns `Prdata` during the access phase of reads.
- It also counts transfers and flags APB protocol violations from the bridge. It serves as the synthesizable peripheral model in bridge integration and as the reference target for the scoreboard.

Parameters:
- `NUM_SLV`, 4: number of banks; equals the width of `Pselx`.
- `DEPTH`, 16: 32-bit words per bank; must be a power of 2.
- `AW`, 32: width of `Paddr`.
- `DW`, 32: width of `Pwdata` and `Prdata`.
- `CNT_W`, 16: width of the transfer counters.

Ports:
- `clock`, in, 1: the single clock; all state updates on its rising edge.
- `Hresetn`, in, 1: synchronous active-low reset.
- `Pselx`, in, `NUM_SLV`: one-hot peripheral select from the bridge.
- `Penable`, in, 1: APB access-phase strobe.
- `Pwrite`, in, 1: 1 = write, 0 = read.
- `Paddr`, in, `AW`: byte address.
- `Pwdata`, in, `DW`: write data.
- `Prdata`, out, `DW`: read data returned to the bridge.
- `wr_cnt`, out, `CNT_W`: number of committed writes; saturates at all-ones.
- `rd_cnt`, out, `CNT_W`: number of completed reads; saturates at all-ones.
- `prot_err`, out, 1: sticky protocol-violation flag.
- `err_code`, out, 3: cause of the first violation; 0 = none.

Behaviour:
- Reset, sampled at a rising edge with `Hresetn`=0:
  - State goes to IDLE.
  - `Prdata`, `wr_cnt`, `rd_cnt`, `prot_err` and `err_code` all go to 0.
  - Every bank word is cleared to 0.
  - Reset asserted mid-transfer aborts the transfer: no write commit, no count.
- FSM states and transitions:
  - IDLE to SETUP when `Pselx` is non-zero and `Penable`=0.
  - SETUP to ACCESS unconditionally on the next edge. Zero wait states; there is no PREADY.
  - ACCESS to SETUP if a new select is present with `Penable`=0 (back-to-back transfer). Otherwise ACCESS to IDLE.
- Setup-phase capture, at the SETUP-entry edge:
  - Latch the bank index (the position of the one-hot bit), the word index `Paddr[2 +: log2(DEPTH)]`, `Pwrite` and `Pwdata`.
  - Upper address bits and `Paddr[1:0]` are ignored. Addresses alias modulo `DEPTH*4`.
- Read timing:
  - At the SETUP-entry edge of a read, `Prdata` is loaded with the addressed word. It is therefore valid through the whole access phase, one cycle after setup.
  - `Prdata` returns to 0 on the edge that leaves ACCESS, unless a new read setup reloads it on that edge.
  - `rd_cnt` increments on the ACCESS-exit edge.
- Write timing:
  - The latched data is written on the edge that leaves ACCESS. `wr_cnt` increments on that edge.
  - A write followed immediately by a read of the same address: the read in the next setup returns the new data (write-first forwarding).
- Counters saturate at `2**CNT_W-1` and do not wrap.
- Protocol checks. The first violation sets `prot_err`=1 and latches `err_code`. Both hold until reset.
  - Code 1: `Penable`=1 while in IDLE, i.e. access without setup.
  - Code 2: `Pselx` is non-zero and not one-hot. The transfer is ignored: no state change, no commit.
  - Code 3: in ACCESS, `Pselx`, `Paddr` or `Pwrite` differs from the setup values, or `Penable`=0. The transfer is still completed using the latched values.
  - Code 4: `Pselx` drops to 0 while in SETUP. Go to IDLE with no commit.
- Simultaneous violations latch the lowest code number.
- Outputs are registered only; there is no combinational path from inputs to `Prdata`.

Decomposition:
- Package `apb_slave_pkg`:
  - FSM state enum `apb_state_e` with values IDLE, SETUP, ACCESS.
  - Error-code constants `ERR_NONE`, `ERR_NOSETUP`, `ERR_MULTISEL`, `ERR_UNSTABLE`, `ERR_DESEL`.
  - Function `onehot_to_idx`.
- One sub-module, `apb_bank_ram`: a `DEPTH`x`DW` register array with synchronous write, synchronous clear and a read port. It is instantiated `NUM_SLV` times via generate.

Test Plan:
1. Reset: hold `Hresetn`=0 for 2 cycles, then read bank 2 word 5 -> `Prdata`=0x0, `rd_cnt`=1, `wr_cnt`=0, `prot_err`=0.
2. Write/read: write 0xDEADBEEF to `Pselx`=4'b0010 at `Paddr`=0x8000_0004, then read the same address -> `Prdata`=0xDEADBEEF during the access phase, 0 after it; `wr_cnt`=1, `rd_cnt`=1.
3. Back-to-back: write 0xA5A5_0001 to `Paddr`=0x0C on bank 0, followed with no idle cycle by a read of 0x0C -> `Prdata`=0xA5A5_0001. Reading `Paddr`=0x4C returns the same value (alias).
4. Bank isolation: write 0x11 to bank 0 word 0 and 0x22 to bank 3 word 0 -> reads return 0x11 and 0x22 respectively.
5. Protocol errors:
   - `Penable`=1 from IDLE -> `prot_err`=1, `err_code`=1.
   - After reset, `Pselx`=4'b0110 -> `err_code`=2, no write.
   - After reset, `Paddr` changes between setup and access -> `err_code`=3; the write lands at the setup address.
6. Saturation and reset mid-write: with `CNT_W`=4, do 20 writes -> `wr_cnt`=15. Assert `Hresetn`=0 during ACCESS of a write -> the word stays 0 and `wr_cnt`=0.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types, error codes and helpers for the APB peripheral memory model.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_NOSETUP  = 3'd1;
    localparam logic [2:0] ERR_MULTISEL = 3'd2;
    localparam logic [2:0] ERR_UNSTABLE = 3'd3;
    localparam logic [2:0] ERR_DESEL    = 3'd4;

    // Position of the set bit of a one-hot vector (0 when no bit is set).
    function automatic int onehot_to_idx(input logic [31:0] sel);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (sel[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_slave_mem_bank.sv
// One peripheral register bank: DEPTH x DW words, synchronous write and clear,
// asynchronous read of the stored contents.
module apb_bank_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                     clock,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage update: clear wins over write
    always_ff @(posedge clock) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB peripheral model: NUM_SLV register banks behind a one-hot select, with
// transfer counters and a sticky protocol-violation monitor.
module apb_slave_mem #(
    parameter int NUM_SLV = 4,
    parameter int DEPTH   = 16,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               Hresetn,
    input  logic [NUM_SLV-1:0] Pselx,
    input  logic               Penable,
    input  logic               Pwrite,
    input  logic [AW-1:0]      Paddr,
    input  logic [DW-1:0]      Pwdata,
    output logic [DW-1:0]      Prdata,
    output logic [CNT_W-1:0]   wr_cnt,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic               prot_err,
    output logic [2:0]         err_code
);
    import apb_slave_pkg::*;

    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int WORD_W = $clog2(DEPTH);

    apb_state_e         state_r;
    apb_state_e         state_s;
    logic [NUM_SLV-1:0] sel_r;
    logic [AW-1:0]      addr_r;
    logic [IDX_W-1:0]   bank_r;
    logic [WORD_W-1:0]  word_r;
    logic               write_r;
    logic [DW-1:0]      wdata_r;

    logic               sel_any_s;
    logic               sel_multi_s;
    logic               new_setup_s;
    logic               capture_s;
    logic               commit_s;
    logic               wr_commit_s;
    logic               rd_done_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [WORD_W-1:0]  word_idx_s;
    logic [DW-1:0]      bank_rdata_s [NUM_SLV];
    logic [DW-1:0]      rd_word_s;
    logic [DW-1:0]      prdata_s;
    logic [2:0]         err_s;
    logic [NUM_SLV-1:0] bank_we_s;

    // Decode the select and address lines of the current bus cycle
    always_comb begin
        sel_any_s   = (Pselx != {NUM_SLV{1'b0}});
        sel_multi_s = sel_any_s && ((Pselx & (Pselx - NUM_SLV'(1))) != {NUM_SLV{1'b0}});
        new_setup_s = sel_any_s && !sel_multi_s && !Penable;
        sel_idx_s   = IDX_W'(onehot_to_idx(32'(Pselx)));
        word_idx_s  = Paddr[2 +: WORD_W];
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!Hresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; a multi-select never starts a transfer and aborts one in flight
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (new_setup_s) state_s = SETUP;
                else             state_s = IDLE;
            end
            SETUP: begin
                if (!sel_any_s || sel_multi_s) state_s = IDLE;
                else                           state_s = ACCESS;
            end
            ACCESS: begin
                if (new_setup_s) state_s = SETUP;
                else             state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs: commit strobes, write-first read data and violation class
    always_comb begin
        commit_s    = (state_r == ACCESS) && !sel_multi_s;
        wr_commit_s = commit_s && write_r;
        rd_done_s   = commit_s && !write_r;
        capture_s   = (state_s == SETUP);

        if (wr_commit_s && (bank_r == sel_idx_s) && (word_r == word_idx_s)) begin
            rd_word_s = wdata_r;
        end else begin
            rd_word_s = bank_rdata_s[sel_idx_s];
        end

        if (capture_s && !Pwrite) begin
            prdata_s = rd_word_s;
        end else if (state_s == ACCESS) begin
            prdata_s = Prdata;
        end else begin
            prdata_s = '0;
        end

        // Within each state the checks are ordered so the lowest code wins.
        // A valid new setup in ACCESS is the back-to-back case, not a violation.
        err_s = ERR_NONE;
        case (state_r)
            IDLE: begin
                if (Penable)          err_s = ERR_NOSETUP;
                else if (sel_multi_s) err_s = ERR_MULTISEL;
                else                  err_s = ERR_NONE;
            end
            SETUP: begin
                if (sel_multi_s)     err_s = ERR_MULTISEL;
                else if (!sel_any_s) err_s = ERR_DESEL;
                else                 err_s = ERR_NONE;
            end
            ACCESS: begin
                if (sel_multi_s) begin
                    err_s = ERR_MULTISEL;
                end else if (!new_setup_s && (!Penable || (Pselx != sel_r) ||
                             (Paddr != addr_r) || (Pwrite != write_r))) begin
                    err_s = ERR_UNSTABLE;
                end else begin
                    err_s = ERR_NONE;
                end
            end
            default: err_s = ERR_NONE;
        endcase

        for (int i = 0; i < NUM_SLV; i++) begin
            bank_we_s[i] = wr_commit_s && (bank_r == IDX_W'(i));
        end
    end

    // Setup capture, read data, saturating counters and sticky error
    always_ff @(posedge clock) begin
        if (!Hresetn) begin
            sel_r    <= '0;
            addr_r   <= '0;
            bank_r   <= '0;
            word_r   <= '0;
            write_r  <= 1'b0;
            wdata_r  <= '0;
            Prdata   <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            prot_err <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (capture_s) begin
                sel_r   <= Pselx;
                addr_r  <= Paddr;
                bank_r  <= sel_idx_s;
                word_r  <= word_idx_s;
                write_r <= Pwrite;
                wdata_r <= Pwdata;
            end
            Prdata <= prdata_s;
            if (wr_commit_s && (wr_cnt != {CNT_W{1'b1}})) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
            if (rd_done_s && (rd_cnt != {CNT_W{1'b1}})) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (!prot_err && (err_s != ERR_NONE)) begin
                prot_err <= 1'b1;
                err_code <= err_s;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_bank
        apb_bank_ram #(
            .DEPTH (DEPTH),
            .DW    (DW)
        ) u_ram (
            .clock (clock),
            .clr   (!Hresetn),
            .we    (bank_we_s[g]),
            .waddr (word_r),
            .wdata (wdata_r),
            .raddr (word_idx_s),
            .rdata (bank_rdata_s[g])
        );
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: directed protocol cases plus a
// randomized transfer stream checked against a plain array memory model.
module tb_apb_slave_mem;

    localparam int NUM_SLV = 4;
    localparam int DEPTH   = 16;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic               clock = 1'b0;
    logic               Hresetn;
    logic [NUM_SLV-1:0] Pselx;
    logic               Penable;
    logic               Pwrite;
    logic [AW-1:0]      Paddr;
    logic [DW-1:0]      Pwdata;
    logic [DW-1:0]      Prdata;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic               prot_err;
    logic [2:0]         err_code;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_m [NUM_SLV][DEPTH];
    int          wr_m;
    int          rd_m;

    always #5 clock = ~clock;

    apb_slave_mem #(
        .NUM_SLV (NUM_SLV),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .DW      (DW),
        .CNT_W   (CNT_W)
    ) dut (
        .clock    (clock),
        .Hresetn  (Hresetn),
        .Pselx    (Pselx),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Prdata   (Prdata),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt),
        .prot_err (prot_err),
        .err_code (err_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr % 32'(DEPTH * 4)) / 4;
    endfunction

    task automatic clear_model();
        for (int b = 0; b < NUM_SLV; b++) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_m[b][w] = 32'h0;
            end
        end
        wr_m = 0;
        rd_m = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(sat(wr_m)));
        check({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(sat(rd_m)));
    endtask

    task automatic bus_idle();
        Pselx   = '0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = '0;
        Pwdata  = '0;
    endtask

    task automatic do_reset();
        Hresetn = 1'b0;
        bus_idle();
        repeat (2) @(posedge clock);
        #1;
        Hresetn = 1'b1;
        clear_model();
        check("rst_prdata", Prdata, 32'h0);
        check_counts("rst");
        check("rst_prot_err", 32'(prot_err), 32'h0);
        check("rst_err_code", 32'(err_code), 32'h0);
    endtask

    // One transfer: setup cycle, two access-phase cycles (SETUP and ACCESS states).
    // With go_idle=0 the caller's next transfer starts in the ACCESS cycle.
    task automatic xfer(input int bank, input logic [31:0] addr, input logic wr,
                        input logic [31:0] data, input bit go_idle);
        int w;
        w       = word_of(addr);
        Pselx   = 4'(32'd1 << bank);
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = data;
        @(posedge clock);
        #1;
        if (!wr) check("rd_setup_prdata", Prdata, mem_m[bank][w]);
        Penable = 1'b1;
        @(posedge clock);
        #1;
        if (!wr) check("rd_access_prdata", Prdata, mem_m[bank][w]);
        if (wr) begin
            mem_m[bank][w] = data;
            wr_m++;
        end else begin
            rd_m++;
        end
        if (go_idle) begin
            @(posedge clock);
            #1;
            check("after_access_prdata", Prdata, 32'h0);
            check_counts("xfer");
            bus_idle();
        end
    endtask

    initial begin
        int          bank;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        bit          idle;

        // Reset, then read of bank 2 word 5
        do_reset();
        xfer(2, 32'h0000_0014, 1'b0, 32'h0, 1'b1);
        check("t1_prot_err", 32'(prot_err), 32'h0);

        // Write then read through a high-order address
        do_reset();
        xfer(1, 32'h8000_0004, 1'b1, 32'hDEAD_BEEF, 1'b1);
        xfer(1, 32'h8000_0004, 1'b0, 32'h0, 1'b1);

        // Back-to-back write then read of the same word, then an aliased read
        do_reset();
        xfer(0, 32'h0000_000C, 1'b1, 32'hA5A5_0001, 1'b0);
        xfer(0, 32'h0000_000C, 1'b0, 32'h0, 1'b1);
        xfer(0, 32'h0000_004C, 1'b0, 32'h0, 1'b1);
        check("b2b_prot_err", 32'(prot_err), 32'h0);

        // Bank isolation at word 0
        do_reset();
        xfer(0, 32'h0, 1'b1, 32'h11, 1'b1);
        xfer(3, 32'h0, 1'b1, 32'h22, 1'b1);
        xfer(0, 32'h0, 1'b0, 32'h0, 1'b1);
        xfer(3, 32'h0, 1'b0, 32'h0, 1'b1);
        xfer(1, 32'h0, 1'b0, 32'h0, 1'b1);

        // Penable high from IDLE, then a later multi-select must not overwrite the code
        do_reset();
        Penable = 1'b1;
        @(posedge clock);
        #1;
        bus_idle();
        check("nosetup_prot_err", 32'(prot_err), 32'h1);
        check("nosetup_err_code", 32'(err_code), 32'h1);
        Pselx = 4'b0110;
        @(posedge clock);
        #1;
        bus_idle();
        check("sticky_err_code", 32'(err_code), 32'h1);

        // Multi-select write is ignored
        do_reset();
        Pselx  = 4'b0110;
        Pwrite = 1'b1;
        Pwdata = 32'h55;
        @(posedge clock);
        #1;
        Penable = 1'b1;
        @(posedge clock);
        #1;
        bus_idle();
        @(posedge clock);
        #1;
        check("multisel_err_code", 32'(err_code), 32'h2);
        check_counts("multisel");
        xfer(1, 32'h0, 1'b0, 32'h0, 1'b1);
        xfer(2, 32'h0, 1'b0, 32'h0, 1'b1);

        // Address changes during the access phase: write lands at the setup address
        do_reset();
        Pselx  = 4'b0001;
        Pwrite = 1'b1;
        Paddr  = 32'h10;
        Pwdata = 32'h77;
        @(posedge clock);
        #1;
        Penable = 1'b1;
        Paddr   = 32'h20;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        bus_idle();
        mem_m[0][4] = 32'h77;
        wr_m = 1;
        check("unstable_err_code", 32'(err_code), 32'h3);
        check_counts("unstable");
        xfer(0, 32'h10, 1'b0, 32'h0, 1'b1);
        xfer(0, 32'h20, 1'b0, 32'h0, 1'b1);

        // Select dropped during SETUP: no commit
        do_reset();
        Pselx  = 4'b0001;
        Pwrite = 1'b1;
        Paddr  = 32'h30;
        Pwdata = 32'h99;
        @(posedge clock);
        #1;
        bus_idle();
        @(posedge clock);
        #1;
        check("desel_err_code", 32'(err_code), 32'h4);
        check_counts("desel");
        xfer(0, 32'h30, 1'b0, 32'h0, 1'b1);

        // Randomized legal traffic, mixing idle gaps and back-to-back transfers
        do_reset();
        for (int n = 0; n < 60; n++) begin
            bank = int'($urandom_range(0, NUM_SLV - 1));
            addr = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 3)) << 2)
                   | 32'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            data = $urandom();
            idle = (n == 59) || ($urandom_range(0, 1) == 1);
            xfer(bank, addr, wr, data, idle);
        end
        check("rand_prot_err", 32'(prot_err), 32'h0);

        // Write counter saturation
        do_reset();
        for (int n = 0; n < 20; n++) begin
            xfer(int'($urandom_range(0, NUM_SLV - 1)), $urandom(), 1'b1, $urandom(), 1'b1);
        end
        check("sat_wr_cnt", 32'(wr_cnt), 32'(CNT_MAX));

        // Reset during the ACCESS cycle of a write aborts it
        Pselx  = 4'b0010;
        Pwrite = 1'b1;
        Paddr  = 32'h8;
        Pwdata = 32'h1234;
        @(posedge clock);
        #1;
        Penable = 1'b1;
        @(posedge clock);
        #1;
        Hresetn = 1'b0;
        @(posedge clock);
        #1;
        Hresetn = 1'b1;
        bus_idle();
        clear_model();
        check("midrst_wr_cnt", 32'(wr_cnt), 32'h0);
        check("midrst_prdata", Prdata, 32'h0);
        xfer(1, 32'h8, 1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
